// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame length,
// odd-parity helper and common keyboard command bytes.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      START,
      SEND,
      WAIT_IDLE
   } ps2_state_t;

   // Device clock falls in one host-to-device frame.
   localparam int PS2_FRAME_FALLS = 11;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_RESET    = 8'hFF;

   // Parity bit that makes data+parity carry an odd number of ones.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer plus history flop for one PS/2 line.
// Ports: clk, resetn (sync, active-low), async_in -> sync, fall.
module ps2_sync_edge (
   input  logic clk,
   input  logic resetn,
   input  logic async_in,
   output logic sync,
   output logic fall
);

   logic [1:0] meta;
   logic       prev;

   // Reset to the idle (high) line level so that leaving reset
   // never produces a spurious falling edge.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         meta <= 2'b11;
         prev <= 1'b1;
      end else begin
         meta <= {meta[0], async_in};
         prev <= meta[1];
      end
   end

   assign sync = meta[1];
   assign fall = prev & ~meta[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data bits,
// odd parity, stop, device ack. Ports: clk, resetn, ps2_clk/ps2_data
// (bus), ps2_clk_oe/ps2_data_oe (pull-low), tx_valid/tx_data/tx_ready,
// done/nack/timeout result pulse.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       done,
   output logic       nack,
   output logic       timeout
);

   import ps2_pkg::*;

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                            INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW = $clog2(CNT_MAX + 1);

   localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_FALLS - 1);

   logic clk_lvl;
   logic clk_fall;
   logic data_lvl;
   logic unused_data_fall;

   ps2_sync_edge u_clk_sync (
      .clk      (clk),
      .resetn   (resetn),
      .async_in (ps2_clk),
      .sync     (clk_lvl),
      .fall     (clk_fall)
   );

   ps2_sync_edge u_data_sync (
      .clk      (clk),
      .resetn   (resetn),
      .async_in (ps2_data),
      .sync     (data_lvl),
      .fall     (unused_data_fall)
   );

   ps2_state_t state;
   ps2_state_t state_next;

   // frame_q[0] is the bit currently on the wire; a device clock
   // fall shifts the next one in: {stop, parity, d7..d0, start}.
   logic [10:0]   frame_q;
   logic [3:0]    bit_cnt;
   logic [CW-1:0] cnt;
   logic          ack_q;
   logic          done_q;
   logic          nack_q;
   logic          to_q;

   logic accept;
   logic inhibit_end;
   logic to_hit;
   logic last_fall;
   logic bus_idle;

   assign accept      = tx_valid && (state == IDLE);
   assign inhibit_end = (cnt == CW'(INHIBIT_CYCLES - 1));
   assign to_hit      = (cnt == CW'(TIMEOUT_CYCLES - 1));
   assign last_fall   = clk_fall && (bit_cnt == LAST_BIT);
   assign bus_idle    = clk_lvl && data_lvl;

   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (accept) state_next = INHIBIT;
         end
         INHIBIT: begin
            if (inhibit_end) state_next = START;
         end
         START: begin
            state_next = SEND;
         end
         SEND: begin
            if (last_fall)
               state_next = WAIT_IDLE;
            else if (!clk_fall && to_hit)
               state_next = IDLE;
         end
         WAIT_IDLE: begin
            if (bus_idle)
               state_next = IDLE;
            else if (!clk_fall && to_hit)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         frame_q <= '0;
         bit_cnt <= '0;
         cnt     <= '0;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
         nack_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         nack_q <= 1'b0;
         to_q   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  frame_q <= {1'b1, odd_parity(tx_data),
                              tx_data, 1'b0};
                  bit_cnt <= '0;
                  cnt     <= '0;
               end
            end
            INHIBIT: begin
               cnt <= cnt + 1'b1;
            end
            START: begin
               cnt     <= '0;
               bit_cnt <= '0;
            end
            SEND: begin
               // A fall in the same cycle as expiry keeps the frame.
               if (clk_fall) begin
                  cnt     <= '0;
                  bit_cnt <= bit_cnt + 1'b1;
                  frame_q <= {1'b1, frame_q[10:1]};
                  if (bit_cnt == LAST_BIT) ack_q <= data_lvl;
               end else if (to_hit) begin
                  done_q <= 1'b1;
                  to_q   <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_IDLE: begin
               if (bus_idle) begin
                  done_q <= 1'b1;
                  nack_q <= ack_q;
               end else if (clk_fall) begin
                  cnt <= '0;
               end else if (to_hit) begin
                  done_q <= 1'b1;
                  to_q   <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      tx_ready    = (state == IDLE);
      ps2_clk_oe  = (state == INHIBIT) || (state == START);
      ps2_data_oe = (state == START) ||
                    ((state == SEND) && !frame_q[0]);
      done        = done_q;
      nack        = nack_q;
      timeout     = to_q;
   end

endmodule
